// File: rtl/montador_digitos_pkg.sv
// Shared types and constants for the keypad digit assembler.
// Defines the packet type, key codes and command packets.
package montador_digitos_pkg;

    localparam int MAX_DIG = 20;

    typedef logic [MAX_DIG-1:0][3:0] senhaPac_t;

    typedef enum logic [1:0] {
        VAZIO,
        DIGITANDO,
        EMITE
    } estado_t;

    localparam logic [3:0] DIG_VAZIO   = 4'hF;
    localparam logic [3:0] TECLA_ASTER = 4'hA;
    localparam logic [3:0] TECLA_HASH  = 4'hB;

    localparam senhaPac_t PAC_VAZIO   = {MAX_DIG{4'hF}};
    localparam senhaPac_t PAC_VOLTA   = {MAX_DIG{4'hB}};
    localparam senhaPac_t PAC_TIMEOUT = {MAX_DIG{4'hE}};

endpackage

// File: rtl/montador_digitos_tick.sv
// Free-running 1 ms strobe generator with synchronous clear.
// Ports: clk, rst (async active-low), clear, tick (1 cycle per ms).
module montador_digitos_tick #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 2;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] LIM = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;

    assign tick = (cnt_q == LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/montador_digitos.sv
// Keypad digit assembler: builds a 20-digit packet from key events.
// Ports: clk, rst, enable, key_value/key_valid in; packet, pulse, count out.
module montador_digitos
    import montador_digitos_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_MS = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output logic [4:0] num_digitos
);

    localparam int TW = $clog2(TIMEOUT_MS + 1);
    localparam logic [TW-1:0] MS_LIM = TW'(TIMEOUT_MS - 1);
    localparam logic [4:0] CNT_MAX = 5'(MAX_DIG);

    estado_t   state_q;
    senhaPac_t buf_q;
    senhaPac_t shifted;
    logic [TW-1:0] ms_q;
    logic [4:0] cnt_q;
    logic tick;
    logic running;
    logic vazio;
    logic acc;
    logic is_dig;
    logic is_hash;
    logic is_aster;
    logic expire;

    assign running  = (state_q == DIGITANDO);
    assign vazio    = !running;
    // Codes 0xC-0xF are not keys: no state change, no timer reload.
    assign acc      = key_valid && enable && (key_value <= TECLA_HASH);
    assign is_dig   = acc && (key_value <= 4'h9);
    assign is_hash  = acc && (key_value == TECLA_HASH);
    assign is_aster = acc && (key_value == TECLA_ASTER);
    // A key on the expiry edge wins over the timeout.
    assign expire   = running && tick && (ms_q == MS_LIM) && !acc;
    assign shifted  = {buf_q[MAX_DIG-2:0], key_value};

    // Prescaler restarts with each key so the timeout is exact.
    montador_digitos_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (!enable || acc || !running),
        .tick  (tick)
    );

    assign num_digitos = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= VAZIO;
            buf_q         <= PAC_VAZIO;
            digitos_value <= PAC_VAZIO;
            digitos_valid <= 1'b0;
            cnt_q         <= '0;
            ms_q          <= '0;
        end else if (!enable) begin
            state_q       <= VAZIO;
            buf_q         <= PAC_VAZIO;
            digitos_value <= PAC_VAZIO;
            digitos_valid <= 1'b0;
            cnt_q         <= '0;
            ms_q          <= '0;
        end else begin
            digitos_valid <= 1'b0;
            if (acc || !running || expire) begin
                ms_q <= '0;
            end else if (tick) begin
                ms_q <= ms_q + 1'b1;
            end
            unique case (1'b1)
                is_dig: begin
                    buf_q         <= shifted;
                    digitos_value <= shifted;
                    cnt_q         <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    state_q       <= DIGITANDO;
                end
                is_hash: begin
                    digitos_value <= buf_q;
                    digitos_valid <= 1'b1;
                    buf_q         <= PAC_VAZIO;
                    cnt_q         <= '0;
                    state_q       <= EMITE;
                end
                is_aster && vazio: begin
                    digitos_value <= PAC_VOLTA;
                    digitos_valid <= 1'b1;
                    state_q       <= EMITE;
                end
                is_aster && !vazio: begin
                    buf_q         <= PAC_VAZIO;
                    digitos_value <= PAC_VAZIO;
                    cnt_q         <= '0;
                    state_q       <= VAZIO;
                end
                expire: begin
                    digitos_value <= PAC_TIMEOUT;
                    digitos_valid <= 1'b1;
                    buf_q         <= PAC_VAZIO;
                    cnt_q         <= '0;
                    state_q       <= EMITE;
                end
                default: begin
                    digitos_value <= buf_q;
                    if (state_q == EMITE) begin
                        state_q <= VAZIO;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montador_digitos.sv
// Directed testbench for the keypad digit assembler.
// Small clock/timeout parameters keep the timeout test short.
module tb_montador_digitos;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic [4:0]  num_digitos;

    int n_chk;
    int n_fail;
    int cyc;
    int seen;

    localparam logic [79:0] ALL_F = 80'hFFFFFFFFFFFFFFFFFFFF;
    localparam logic [79:0] ALL_B = 80'hBBBBBBBBBBBBBBBBBBBB;
    localparam logic [79:0] ALL_E = 80'hEEEEEEEEEEEEEEEEEEEE;

    montador_digitos #(
        .CLK_HZ     (4000),
        .TIMEOUT_MS (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_value     (key_value),
        .key_valid     (key_valid),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .num_digitos   (num_digitos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        key_value = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int limit);
        cyc = 0;
        seen = 0;
        while (cyc < limit && seen == 0) begin
            step();
            cyc++;
            if (digitos_valid) seen = 1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        enable = 1'b1;
        key_value = 4'h0;
        key_valid = 1'b0;
        #12;
        chk("rst_val", digitos_value, ALL_F);
        chk("rst_vld", 80'(digitos_valid), 80'd0);
        chk("rst_num", 80'(num_digitos), 80'd0);
        rst = 1'b1;
        step();

        key(4'h1);
        chk("k1", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF1);
        chk("k1_num", 80'(num_digitos), 80'd1);
        key(4'h2);
        chk("k12", digitos_value, 80'hFFFFFFFFFFFFFFFFFF12);
        key(4'h3);
        chk("k123", digitos_value, 80'hFFFFFFFFFFFFFFFFF123);
        key(4'h4);
        chk("k1234", digitos_value, 80'hFFFFFFFFFFFFFFFF1234);
        chk("k1234_num", 80'(num_digitos), 80'd4);
        key(4'hB);
        chk("hash_vld", 80'(digitos_valid), 80'd1);
        chk("hash_pkt", digitos_value, 80'hFFFFFFFFFFFFFFFF1234);
        step();
        chk("hash_end_vld", 80'(digitos_valid), 80'd0);
        chk("hash_end_val", digitos_value, ALL_F);
        chk("hash_end_num", 80'(num_digitos), 80'd0);

        key(4'hB);
        chk("empty_hash_vld", 80'(digitos_valid), 80'd1);
        chk("empty_hash_pkt", digitos_value, ALL_F);
        step();
        chk("empty_hash_end", 80'(digitos_valid), 80'd0);

        key(4'hA);
        chk("back_vld", 80'(digitos_valid), 80'd1);
        chk("back_pkt", digitos_value, ALL_B);
        step();
        chk("back_end_vld", 80'(digitos_valid), 80'd0);
        chk("back_end_val", digitos_value, ALL_F);

        for (int i = 0; i < 22; i++) key(4'(i % 10));
        chk("sat_num", 80'(num_digitos), 80'd20);
        chk("sat_val", digitos_value, 80'h23456789012345678901);
        key(4'hB);
        chk("sat_vld", 80'(digitos_valid), 80'd1);
        chk("sat_pkt", digitos_value, 80'h23456789012345678901);
        step();
        chk("sat_end_num", 80'(num_digitos), 80'd0);

        key(4'h1);
        key(4'hB);
        chk("b2b_pulse", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF1);
        key(4'h5);
        chk("b2b_vld", 80'(digitos_valid), 80'd0);
        chk("b2b_val", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF5);
        chk("b2b_num", 80'(num_digitos), 80'd1);
        key(4'hA);

        key(4'hC);
        chk("ign_val", digitos_value, ALL_F);
        chk("ign_vld", 80'(digitos_valid), 80'd0);

        key(4'h7);
        wait_pulse(30);
        chk("to_seen", 80'(seen), 80'd1);
        chk("to_lat", 80'(cyc), 80'd12);
        chk("to_pkt", digitos_value, ALL_E);
        step();
        chk("to_end_val", digitos_value, ALL_F);
        chk("to_end_num", 80'(num_digitos), 80'd0);

        key(4'h7);
        seen = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (digitos_valid) seen = 1;
        end
        chk("pre_exp_quiet", 80'(seen), 80'd0);
        key(4'h3);
        chk("exp_key_vld", 80'(digitos_valid), 80'd0);
        chk("exp_key_val", digitos_value, 80'hFFFFFFFFFFFFFFFFFF73);
        wait_pulse(30);
        chk("restart_lat", 80'(cyc), 80'd12);
        chk("restart_pkt", digitos_value, ALL_E);
        step();

        key(4'h5);
        key(4'h6);
        key(4'hA);
        chk("clr_val", digitos_value, ALL_F);
        chk("clr_vld", 80'(digitos_valid), 80'd0);
        chk("clr_num", 80'(num_digitos), 80'd0);

        key(4'h5);
        key(4'h6);
        enable = 1'b0;
        step();
        chk("dis_val", digitos_value, ALL_F);
        chk("dis_vld", 80'(digitos_valid), 80'd0);
        key(4'h5);
        chk("dis_key_val", digitos_value, ALL_F);
        chk("dis_key_num", 80'(num_digitos), 80'd0);
        enable = 1'b1;
        key(4'h5);
        chk("en_key", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF5);
        key(4'hA);

        key(4'h9);
        key(4'h8);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_val", digitos_value, ALL_F);
        chk("arst_num", 80'(num_digitos), 80'd0);
        chk("arst_vld", 80'(digitos_valid), 80'd0);
        #2;
        rst = 1'b1;
        step();
        key(4'h9);
        chk("post_rst", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF9);
        chk("post_rst_num", 80'(num_digitos), 80'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
